wbu_mc: RTL and testbench
=========================

Name: wbu_mc

Overview:
Multi-channel write-back unit; the next generation of the single-port write-back stage.
- Accepts completed results from NCH independent producer channels (e.g. ALU, LSU, MDU), each with its own valid/ready handshake.
- Buffers results per channel, arbitrates round-robin onto the single GPR write port, and keeps a retire counter.
- Sits between the execute/memory stages and the GPR file; flush comes from the trap/CSR logic.

Parameters:
NCH, 3, number of producer channels (1..8)
DEPTH, 2, entries per channel buffer (power of two, >=2)
XLEN, 64, data width
RADDR_W, 5, GPR address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered and incoming results
in_valid  in  NCH  per-channel result valid
in_ready  out  NCH  per-channel buffer can accept
in_wen  in  NCH  per-channel result writes a GPR
in_rd  in  NCH*RADDR_W  per-channel destination, channel i at [i*RADDR_W +: RADDR_W]
in_data  in  NCH*XLEN  per-channel result, channel i at [i*XLEN +: XLEN]
gpr_wen  out  1  registered GPR write enable
gpr_waddr  out  RADDR_W  registered GPR write address
gpr_wdata  out  XLEN  registered GPR write data
retire_valid  out  1  registered: one entry retired last cycle
retire_ch  out  clog2(NCH) (min 1)  channel of retired entry
retire_cnt  out  64  total retired entries
busy  out  1  any buffer non-empty

Behaviour:
- Reset (async, rst_n low): all buffers empty, RR pointer = 0, retire_cnt = 0, gpr_wen = 0, gpr_waddr = 0, gpr_wdata = 0, retire_valid = 0, retire_ch = 0. After release, in_ready = all ones and busy = 0. Reset mid-transfer drops everything, with no partial writes.
- Handshake: a push on channel i occurs when in_valid[i] && in_ready[i] at a clk edge.
  - in_ready[i] = !full[i] && !flush (combinational). No same-cycle pop-to-push bypass.
  - in_valid must not depend on in_ready.
- Buffer: per-channel circular FIFO of {wen, rd, data}, DEPTH entries. Pointers are one bit wider than log2(DEPTH) for full/empty detection and wrap modulo 2*DEPTH.
- Arbiter:
  - Each cycle, when !flush, grants the first non-empty channel scanning ptr, ptr+1, ... mod NCH.
  - On a grant to channel g, pop g and set ptr = (g+1) mod NCH. With no grant, ptr holds.
- Output register: written on the edge after a grant.
  - gpr_wen = entry.wen && (entry.rd != 0); gpr_waddr = entry.rd; gpr_wdata = entry.data.
  - retire_valid = 1, retire_ch = g.
  - With no grant: gpr_wen = 0, retire_valid = 0; addr/data hold.
- Writes to x0 are retired (counted, retire_valid = 1) but gpr_wen = 0.
- Latency: push at edge N -> earliest gpr_wen at edge N+1 (visible the cycle after N+1). Throughput is one retire per cycle total.
- Ordering: FIFO order is preserved within a channel. No ordering is guaranteed across channels; producers guarantee no cross-channel WAW to the same rd in flight.
- retire_cnt increments by 1 on each grant and wraps 2^64-1 -> 0.
- flush:
  - At the edge: all buffers emptied and pushes in the flush cycle ignored.
  - No grant in the flush cycle, so the next-cycle gpr_wen = 0 and retire_valid = 0.
  - RR pointer and retire_cnt hold.
- Simultaneous push and pop on one channel: both occur, occupancy unchanged.
- busy = OR of !empty[i], combinational.

Decomposition:
- Shared include wbu_defs.vh: entry field offsets/width (ENTRY_W = 1+RADDR_W+XLEN), clog2 helper function.
- One sub-module wb_fifo (DEPTH, WIDTH; push, pop, flush, full, empty, head data), instantiated NCH times via generate.
- Arbiter and output register stay in wbu_mc.

Test Plan:
- Reset/idle: hold rst_n=0 then release -> in_ready=3'b111, busy=0, retire_cnt=0, gpr_wen=0 for 10 idle cycles.
- Single write: ch1 pushes wen=1, rd=5, data=0xDEAD_BEEF -> next cycle gpr_wen=1, waddr=5, wdata=0xDEADBEEF, retire_ch=1, retire_cnt=1.
- Round-robin fairness: all 3 channels push 4 entries each in the same cycles -> grants ch0,ch1,ch2,ch0,... with per-channel FIFO order kept; retire_cnt=12.
- Full/backpressure: DEPTH=2, ch0 pushes 3 back-to-back while ch1/ch2 keep the arbiter away from ch0 -> in_ready[0]=0 after 2 entries, third accepted only after the ch0 pop, no loss or duplication.
- x0 and flush: push rd=0 wen=1 -> retire_valid=1, gpr_wen=0. Fill all buffers, assert flush 1 cycle -> next cycle busy=0, gpr_wen=0, retire_cnt unchanged.
- Counter wrap and async reset: preload retire_cnt to 2^64-1 via force, retire 1 -> 0. Assert rst_n low mid-stream -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wbu_mc_pkg.sv
// wbu_mc_pkg: shared helpers for the multi-channel write-back unit.
//   clog2_min1 : ceil(log2(n)), never below 1 (for channel-index widths)
//   entry_w    : width of one buffered entry {wen, rd, data}
// Entry layout (LSB first): data [XLEN-1:0], rd [XLEN +: RADDR_W], wen at the top.
package wbu_mc_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int entry_w(input int raddr_w, input int xlen);
    return 1 + raddr_w + xlen;
  endfunction

  function automatic int entry_rd_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int entry_wen_bit(input int raddr_w, input int xlen);
    return xlen + raddr_w;
  endfunction

endpackage

// File: rtl/wbu_mc_wb_fifo.sv
// wb_fifo: per-channel circular result buffer.
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the buffer at the next edge, ignores a same-cycle push
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wbu_mc.sv
// wbu_mc: multi-channel write-back unit.
//   clk, rst_n   : core clock, async active-low reset
//   flush        : discard all buffered and incoming results
//   in_valid/in_ready/in_wen/in_rd/in_data : NCH producer channels, packed per channel
//   gpr_wen/gpr_waddr/gpr_wdata            : registered GPR write port
//   retire_valid/retire_ch/retire_cnt      : registered retire report and running count
//   busy         : any channel buffer holds an entry
// One entry per cycle is granted round-robin across the channel buffers and
// registered onto the GPR port. Writes to x0 retire but never assert gpr_wen.
module wbu_mc
  import wbu_mc_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int DEPTH   = 2,
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NCH-1:0]              in_valid,
  output logic [NCH-1:0]              in_ready,
  input  logic [NCH-1:0]              in_wen,
  input  logic [NCH*RADDR_W-1:0]      in_rd,
  input  logic [NCH*XLEN-1:0]         in_data,
  output logic                        gpr_wen,
  output logic [RADDR_W-1:0]          gpr_waddr,
  output logic [XLEN-1:0]             gpr_wdata,
  output logic                        retire_valid,
  output logic [clog2_min1(NCH)-1:0]  retire_ch,
  output logic [63:0]                 retire_cnt,
  output logic                        busy
);

  localparam int CH_W    = clog2_min1(NCH);
  localparam int EW      = entry_w(RADDR_W, XLEN);
  localparam int RD_LSB  = entry_rd_lsb(XLEN);
  localparam int WEN_BIT = entry_wen_bit(RADDR_W, XLEN);

  logic [NCH-1:0]  full;
  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop;
  logic [EW-1:0]   head [NCH];
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ptr_nxt;
  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  logic [EW-1:0]   sel;
  logic [RADDR_W-1:0] sel_rd;
  int              idx;

  assign in_ready = ~full & {NCH{~flush}};
  assign push     = in_valid & in_ready;
  assign busy     = |(~empty);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata ({in_wen[i], in_rd[i*RADDR_W +: RADDR_W], in_data[i*XLEN +: XLEN]}),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Round-robin scan starting at ptr; first non-empty channel wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    pop       = '0;
    ptr_nxt   = ptr;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!grant_vld && !flush && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
    if (grant_vld) begin
      pop[grant_ch] = 1'b1;
      if (int'(grant_ch) == NCH - 1) ptr_nxt = '0;
      else                           ptr_nxt = grant_ch + CH_W'(1);
    end
  end

  assign sel    = head[grant_ch];
  assign sel_rd = sel[RD_LSB +: RADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      gpr_wen      <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      retire_valid <= 1'b0;
      retire_ch    <= '0;
      retire_cnt   <= '0;
    end else begin
      gpr_wen      <= 1'b0;
      retire_valid <= 1'b0;
      if (grant_vld) begin
        gpr_wen      <= sel[WEN_BIT] && (sel_rd != '0);
        gpr_waddr    <= sel_rd;
        gpr_wdata    <= sel[XLEN-1:0];
        retire_valid <= 1'b1;
        retire_ch    <= grant_ch;
        retire_cnt   <= retire_cnt + 64'd1;
        ptr          <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_wbu_mc.sv
// tb_wbu_mc: directed self-checking bench for wbu_mc (NCH=3, DEPTH=2).
module tb_wbu_mc;

  localparam int NCH     = 3;
  localparam int DEPTH   = 2;
  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [NCH-1:0]         in_wen;
  logic [NCH*RADDR_W-1:0] in_rd;
  logic [NCH*XLEN-1:0]    in_data;
  logic                   gpr_wen;
  logic [RADDR_W-1:0]     gpr_waddr;
  logic [XLEN-1:0]        gpr_wdata;
  logic                   retire_valid;
  logic [1:0]             retire_ch;
  logic [63:0]            retire_cnt;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  int idx [NCH];
  bit rdy [NCH];
  int k;
  int ech;
  int ej;

  always #5 clk = ~clk;

  wbu_mc #(
    .NCH     (NCH),
    .DEPTH   (DEPTH),
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wen       (in_wen),
    .in_rd        (in_rd),
    .in_data      (in_data),
    .gpr_wen      (gpr_wen),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .retire_valid (retire_valid),
    .retire_ch    (retire_ch),
    .retire_cnt   (retire_cnt),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic wen,
                       input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] data);
    in_valid[ch]                  = v;
    in_wen[ch]                    = wen;
    in_rd[ch*RADDR_W +: RADDR_W]  = rd;
    in_data[ch*XLEN +: XLEN]      = data;
  endtask

  task automatic check_retire(input string tag, input logic [1:0] ch,
                              input logic wen, input logic [RADDR_W-1:0] rd,
                              input logic [XLEN-1:0] data);
    check({tag, "_rv"},   64'(retire_valid), 64'd1);
    check({tag, "_ch"},   64'(retire_ch),    64'(ch));
    check({tag, "_wen"},  64'(gpr_wen),      64'(wen));
    check({tag, "_addr"}, 64'(gpr_waddr),    64'(rd));
    check({tag, "_data"}, gpr_wdata,         data);
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = '0;
    in_wen   = '0;
    in_rd    = '0;
    in_data  = '0;

    // ---------------- reset / idle
    #12;
    check("rst_gpr_wen",  64'(gpr_wen),      64'd0);
    check("rst_waddr",    64'(gpr_waddr),    64'd0);
    check("rst_wdata",    gpr_wdata,         64'd0);
    check("rst_rv",       64'(retire_valid), 64'd0);
    check("rst_ch",       64'(retire_ch),    64'd0);
    check("rst_cnt",      retire_cnt,        64'd0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_ready", 64'(in_ready),  64'h7);
      check("idle_busy",  64'(busy),      64'd0);
      check("idle_cnt",   retire_cnt,     64'd0);
      check("idle_wen",   64'(gpr_wen),   64'd0);
    end

    // ---------------- single write on ch1
    drive(1, 1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF);
    cyc();
    drive(1, 1'b0, 1'b0, 5'd0, 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    cyc();
    check_retire("single", 2'd1, 1'b1, 5'd5, 64'hDEAD_BEEF);
    check("single_cnt", retire_cnt, 64'd1);
    cyc();
    check("single_after_rv",   64'(retire_valid), 64'd0);
    check("single_after_wen",  64'(gpr_wen),      64'd0);
    check("single_after_busy", 64'(busy),         64'd0);
    check("single_hold_addr",  64'(gpr_waddr),    64'd5);

    // ---------------- round-robin fairness, fresh reset so ptr starts at 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    for (int c = 0; c < NCH; c++) idx[c] = 0;
    k = 0;
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (idx[c] < 4) begin
          drive(c, 1'b1, 1'b1, 5'(1 + c*4 + idx[c]),
                64'hA000_0000_0000_0000 | 64'(c << 8) | 64'(idx[c]));
          rdy[c] = in_ready[c];
        end else begin
          drive(c, 1'b0, 1'b0, 5'd0, 64'd0);
          rdy[c] = 1'b0;
        end
      end
      cyc();
      for (int c = 0; c < NCH; c++) if (rdy[c]) idx[c]++;
      if (retire_valid) begin
        if (k < 12) begin
          ech = k % 3;
          ej  = k / 3;
          check_retire($sformatf("rr%0d", k), 2'(ech), 1'b1, 5'(1 + ech*4 + ej),
                       64'hA000_0000_0000_0000 | 64'(ech << 8) | 64'(ej));
        end
        k++;
      end
    end
    in_valid = '0;
    check("rr_retires", 64'(k),    64'd12);
    check("rr_cnt",     retire_cnt, 64'd12);
    check("rr_busy",    64'(busy),  64'd0);

    // ---------------- x0 write: retired but no GPR write (ptr 0 -> 1)
    drive(0, 1'b1, 1'b1, 5'd0, 64'h1234);
    cyc();
    drive(0, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc();
    check_retire("x0", 2'd0, 1'b0, 5'd0, 64'h1234);
    check("x0_cnt", retire_cnt, 64'd13);

    // ---------------- backpressure on ch0 (ptr = 1)
    drive(0, 1'b1, 1'b1, 5'd20, 64'h100);
    drive(1, 1'b1, 1'b1, 5'd21, 64'h201);
    drive(2, 1'b1, 1'b1, 5'd22, 64'h302);
    cyc();
    check("bp_ready_c1", 64'(in_ready), 64'h7);
    drive(1, 1'b0, 1'b0, 5'd0, 64'd0);
    drive(2, 1'b0, 1'b0, 5'd0, 64'd0);
    drive(0, 1'b1, 1'b1, 5'd23, 64'h101);
    cyc();
    check_retire("bp_r1", 2'd1, 1'b1, 5'd21, 64'h201);
    check("bp_ready0_c2", 64'(in_ready[0]), 64'd0);
    drive(0, 1'b1, 1'b1, 5'd24, 64'h102);
    cyc();
    check_retire("bp_r2", 2'd2, 1'b1, 5'd22, 64'h302);
    check("bp_ready0_c3", 64'(in_ready[0]), 64'd0);
    cyc();
    check_retire("bp_r3", 2'd0, 1'b1, 5'd20, 64'h100);
    check("bp_ready0_c4", 64'(in_ready[0]), 64'd1);
    cyc();
    drive(0, 1'b0, 1'b0, 5'd0, 64'd0);
    check_retire("bp_r4", 2'd0, 1'b1, 5'd23, 64'h101);
    cyc();
    check_retire("bp_r5", 2'd0, 1'b1, 5'd24, 64'h102);
    cyc();
    check("bp_done_rv",   64'(retire_valid), 64'd0);
    check("bp_done_busy", 64'(busy),         64'd0);
    check("bp_done_cnt",  retire_cnt,        64'd18);

    // ---------------- flush (ptr = 1)
    for (int c = 0; c < NCH; c++) drive(c, 1'b1, 1'b1, 5'(8 + c), 64'(16'hF00 + c));
    cyc();
    cyc();
    check("fl_pre_ch",  64'(retire_ch),  64'd1);
    check("fl_pre_cnt", retire_cnt,      64'd19);
    check("fl_pre_busy", 64'(busy),      64'd1);
    flush = 1'b1;
    #1;
    check("fl_ready", 64'(in_ready), 64'd0);
    cyc();
    flush    = 1'b0;
    in_valid = '0;
    check("fl_busy", 64'(busy),         64'd0);
    check("fl_wen",  64'(gpr_wen),      64'd0);
    check("fl_rv",   64'(retire_valid), 64'd0);
    check("fl_cnt",  retire_cnt,        64'd19);
    // ptr held at 2 across the flush, so ch2 wins over ch0
    drive(0, 1'b1, 1'b1, 5'd3, 64'hC0);
    drive(2, 1'b1, 1'b1, 5'd4, 64'hC2);
    cyc();
    in_valid = '0;
    cyc();
    check_retire("fl_ptr_a", 2'd2, 1'b1, 5'd4, 64'hC2);
    cyc();
    check_retire("fl_ptr_b", 2'd0, 1'b1, 5'd3, 64'hC0);
    check("fl_ptr_cnt", retire_cnt, 64'd21);
    cyc();

    // ---------------- retire counter wrap (ptr = 1)
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    #1;
    check("wrap_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 1'b1, 1'b1, 5'd9, 64'h55);
    cyc();
    in_valid = '0;
    cyc();
    check_retire("wrap", 2'd1, 1'b1, 5'd9, 64'h55);
    check("wrap_cnt", retire_cnt, 64'd0);
    cyc();

    // ---------------- async reset mid-stream (ptr = 2)
    drive(1, 1'b1, 1'b1, 5'd10, 64'h77);
    drive(2, 1'b1, 1'b1, 5'd11, 64'h88);
    cyc();
    in_valid = '0;
    cyc();
    check_retire("ar_pre", 2'd2, 1'b1, 5'd11, 64'h88);
    check("ar_pre_busy", 64'(busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_wen",   64'(gpr_wen),      64'd0);
    check("ar_waddr", 64'(gpr_waddr),    64'd0);
    check("ar_wdata", gpr_wdata,         64'd0);
    check("ar_rv",    64'(retire_valid), 64'd0);
    check("ar_ch",    64'(retire_ch),    64'd0);
    check("ar_cnt",   retire_cnt,        64'd0);
    check("ar_busy",  64'(busy),         64'd0);
    check("ar_ready", 64'(in_ready),     64'h7);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ar_post_wen",  64'(gpr_wen),      64'd0);
      check("ar_post_rv",   64'(retire_valid), 64'd0);
      check("ar_post_busy", 64'(busy),         64'd0);
      check("ar_post_cnt",  retire_cnt,        64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
